mcb_port_responder: RTL and testbench
=====================================

Name: mcb_port_responder

Overview:
- Synthesizable stand-in for one Spartan-6 MCB user port (command, write and read FIFOs), backed by on-chip block RAM.
- It is the responder end of the interface that the memory manager drives. It accepts commands and write words, and returns read words with MCB-like flags and latency.
- It is used for simulation and for board builds without external LPDDR.

Parameters:
- ADDR_WORDS_LOG2, 10, log2 of backing memory depth in 32-bit words.
- CMD_DEPTH_LOG2, 2, log2 of command FIFO depth.
- DATA_DEPTH_LOG2, 6, log2 of write/read FIFO depth (64 entries).
- CALIB_CYCLES, 16, cycles after reset release before calib_done rises.
- READ_LATENCY, 4, cycles from read-command pop to first read word pushed.
- REFRESH_CYCLES, 8, busy cycles consumed by a refresh command.

Ports:
- clk  in  1  single clock for all three FIFOs and the engine.
- rst_n  in  1  reset; asynchronous assert, active-low.
- calib_done  out  1  high once calibration delay expires.
- cmd_en  in  1  push command.
- cmd_instr  in  3  0=write, 1=read, 2=write-autoprecharge, 3=read-autoprecharge, 4=refresh.
- cmd_bl  in  6  burst length minus 1.
- cmd_byte_addr  in  30  byte address.
- cmd_empty  out  1  command FIFO empty flag.
- cmd_full  out  1  command FIFO full flag.
- wr_en  in  1  push write word.
- wr_mask  in  4  byte mask; bit=1 means the byte is not written.
- wr_data  in  32  write word.
- wr_full  out  1  write FIFO full flag.
- wr_empty  out  1  write FIFO empty flag.
- wr_count  out  7  write FIFO occupancy.
- wr_underrun  out  1  sticky write-underrun flag.
- wr_error  out  1  sticky write-error flag.
- rd_en  in  1  pop read word.
- rd_data  out  32  read FIFO head (show-ahead).
- rd_full  out  1  read FIFO full flag.
- rd_empty  out  1  read FIFO empty flag.
- rd_count  out  7  read FIFO occupancy.
- rd_overflow  out  1  sticky read-overflow flag.
- rd_error  out  1  sticky read-error flag.

Behaviour:
- Reset values:
  - calib_done=0; all *_empty=1; all *_full=0; counts=0; sticky flags=0; rd_data=0.
  - FSM in CALIB. Memory contents are not reset.
  - Reset asserted mid-burst aborts the burst and flushes all FIFOs.
- FIFO pushes and pops:
  - Accepted in any state, including before calib_done.
  - A push while full is dropped. A write push while full sets wr_error.
  - A pop while empty is ignored and sets rd_error.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Flags and counts update the cycle after the operation.
- Address and burst:
  - Word address = cmd_byte_addr[ADDR_WORDS_LOG2+1:2]; cmd_byte_addr[1:0] is ignored.
  - Within a burst the address increments by 1 word per word and wraps modulo 2^ADDR_WORDS_LOG2.
  - Burst length = cmd_bl+1, range 1..64.
- FSM states:
  - CALIB: count CALIB_CYCLES cycles, then set calib_done (stays 1 until reset) and go to IDLE.
  - IDLE: if the command FIFO is non-empty, pop the command, latch its fields and go to DECODE.
  - DECODE: instr 0/2 -> WRITE; instr 1/3 -> RD_WAIT; instr 4 -> REFRESH; instr 5-7 -> IDLE (discarded, no flag).
  - WRITE: each cycle the write FIFO is non-empty, pop one word and write the unmasked bytes.
    - If the write FIFO is empty, stall and set wr_underrun and wr_error (both sticky).
    - After the last word, go to IDLE.
  - RD_WAIT: wait READ_LATENCY-1 cycles, then go to READ.
  - READ: one word per cycle, using a 1-cycle synchronous RAM read, pushed into the read FIFO.
    - If the read FIFO is full, the word is dropped and rd_overflow is set; the engine does not stall.
    - After the last word, go to IDLE.
  - REFRESH: busy REFRESH_CYCLES cycles, then go to IDLE.
- Read-after-write ordering: commands execute strictly in order, so a read issued after a write returns the written data.

Optional Feature:
- Macro: MCB_RESP_STALL_INJECT_EN.
- With the macro defined: a 16-bit LFSR (seed 0xACE1, advanced every cycle) inserts an idle cycle whenever bit 0 = 1.
  - Idle cycles are inserted before each WRITE/READ word and in IDLE before each pop.
  - Purpose: stress the initiator's wait states.
- Without the macro: no injected stalls; timing is exactly as stated in Behaviour.

Decomposition:
- Package mcb_port_pkg holds:
  - instruction code constants (WRITE=0, READ=1, WRITE_AP=2, READ_AP=3, REFRESH=4);
  - the FSM state enum;
  - the LFSR seed constant.
- Sub-module mcb_sync_fifo: parameterised width/depth, show-ahead, with count, full and empty outputs. It is instantiated for the command, write and read FIFOs.

Test Plan:
- Release reset -> calib_done rises exactly CALIB_CYCLES=16 cycles later; all flags hold their reset values until then.
- Push wr_data=0xF0806020 (mask 0), then write cmd (addr 0x40, bl=0), then read cmd (same addr, bl=0) -> rd_empty falls, rd_data=0xF0806020, and wr_empty=1 before the read word appears.
- Write 0xFFFFFFFF to addr 0x10, then write 0x00000000 with mask 4'b1010 to the same addr, then read it -> rd_data=0xFF00FF00.
- Write cmd with bl=3 and only 2 words in the write FIFO -> wr_underrun=1 and wr_error=1; the engine stalls; 2 more pushes complete the burst; reading back returns 4 words in order.
- Read burst bl=63 with the read FIFO pre-filled with 10 words and rd_en held 0 -> rd_full=1 and rd_overflow=1; rd_count=64.
- Write at word address 1023 with bl=1 -> the second word lands at word address 0 (wrap); reset asserted mid-burst -> FIFOs empty and calib_done=0 immediately.

Source files
------------

// File: rtl/mcb_port_pkg.sv
// Shared definitions for the MCB user-port responder: instruction codes,
// engine state encoding and the stall-injection LFSR seed/step.
package mcb_port_pkg;

    // Command instruction codes as presented on cmd_instr
    localparam logic [2:0] INSTR_WRITE    = 3'd0;
    localparam logic [2:0] INSTR_READ     = 3'd1;
    localparam logic [2:0] INSTR_WRITE_AP = 3'd2;
    localparam logic [2:0] INSTR_READ_AP  = 3'd3;
    localparam logic [2:0] INSTR_REFRESH  = 3'd4;

    // Memory engine states
    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_READ,
        ST_REFRESH
    } engine_state_t;

    // Seed of the stall-injection LFSR
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One step of a maximal-length 16-bit Fibonacci LFSR (taps 16,14,13,11)
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mcb_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and full/empty flags.
// A push while full and a pop while empty are ignored and reported on the
// push_dropped / pop_ignored strobes so the owner can keep sticky flags.
module mcb_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  push_dropped,
    output logic                  pop_ignored
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    // The count never exceeds DEPTH, so its MSB alone marks "full"
    assign full         = count_reg[DEPTH_LOG2];
    assign empty        = (count_reg == '0);
    assign count        = count_reg;
    assign do_push      = push && !full;
    assign do_pop       = pop && !empty;
    assign push_dropped = push && full;
    assign pop_ignored  = pop && empty;

    // Show-ahead head; reads as zero while empty so the port is clean at reset
    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mcb_port_responder.sv
// Block-RAM backed stand-in for one Spartan-6 MCB user port: command, write
// and read FIFOs in front of a small in-order memory engine.
// Optional: define MCB_RESP_STALL_INJECT_EN to insert LFSR-driven idle cycles
// before each pop in IDLE and before each WRITE/READ word.
module mcb_port_responder
    import mcb_port_pkg::*;
#(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int CMD_DEPTH_LOG2  = 2,
    parameter int DATA_DEPTH_LOG2 = 6,
    parameter int CALIB_CYCLES    = 16,
    parameter int READ_LATENCY    = 4,
    parameter int REFRESH_CYCLES  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       calib_done,
    input  logic                       cmd_en,
    input  logic [2:0]                 cmd_instr,
    input  logic [5:0]                 cmd_bl,
    input  logic [29:0]                cmd_byte_addr,
    output logic                       cmd_empty,
    output logic                       cmd_full,
    input  logic                       wr_en,
    input  logic [3:0]                 wr_mask,
    input  logic [31:0]                wr_data,
    output logic                       wr_full,
    output logic                       wr_empty,
    output logic [DATA_DEPTH_LOG2:0]   wr_count,
    output logic                       wr_underrun,
    output logic                       wr_error,
    input  logic                       rd_en,
    output logic [31:0]                rd_data,
    output logic                       rd_full,
    output logic                       rd_empty,
    output logic [DATA_DEPTH_LOG2:0]   rd_count,
    output logic                       rd_overflow,
    output logic                       rd_error
);

    localparam int          AW           = ADDR_WORDS_LOG2;
    localparam int          CMD_W        = 3 + 6 + AW;
    localparam int          WORDS        = 1 << AW;
    localparam logic [15:0] CALIB_LAST   = 16'(CALIB_CYCLES - 1);
    localparam logic [15:0] RD_WAIT_LAST = 16'(READ_LATENCY - 2);
    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CYCLES - 1);

    // Command FIFO: only the word address is kept, byte offset and high bits are dropped
    logic [CMD_W-1:0]        cmd_push_data;
    logic [CMD_W-1:0]        cmd_head;
    logic                    cmd_pop;
    logic [CMD_DEPTH_LOG2:0] cmd_count_unused;
    logic                    cmd_drop_unused;
    logic                    cmd_pop_err_unused;
    logic                    addr_bits_unused;

    assign cmd_push_data    = {cmd_instr, cmd_bl, cmd_byte_addr[AW+1:2]};
    assign addr_bits_unused = ^{cmd_byte_addr[29:AW+2], cmd_byte_addr[1:0]};

    mcb_sync_fifo #(.WIDTH(CMD_W), .DEPTH_LOG2(CMD_DEPTH_LOG2)) u_cmd_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (cmd_en),
        .push_data    (cmd_push_data),
        .pop          (cmd_pop),
        .head_data    (cmd_head),
        .full         (cmd_full),
        .empty        (cmd_empty),
        .count        (cmd_count_unused),
        .push_dropped (cmd_drop_unused),
        .pop_ignored  (cmd_pop_err_unused)
    );

    // Write FIFO carries {mask, data}
    logic [35:0] wr_head;
    logic        wr_pop;
    logic        wr_push_dropped;
    logic        wr_pop_err_unused;

    mcb_sync_fifo #(.WIDTH(36), .DEPTH_LOG2(DATA_DEPTH_LOG2)) u_wr_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (wr_en),
        .push_data    ({wr_mask, wr_data}),
        .pop          (wr_pop),
        .head_data    (wr_head),
        .full         (wr_full),
        .empty        (wr_empty),
        .count        (wr_count),
        .push_dropped (wr_push_dropped),
        .pop_ignored  (wr_pop_err_unused)
    );

    // Read FIFO is fed one cycle after each RAM read is issued
    logic [31:0] ram_q;
    logic        rd_push_reg;
    logic        rd_push_dropped;
    logic        rd_pop_ignored;

    mcb_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DATA_DEPTH_LOG2)) u_rd_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (rd_push_reg),
        .push_data    (ram_q),
        .pop          (rd_en),
        .head_data    (rd_data),
        .full         (rd_full),
        .empty        (rd_empty),
        .count        (rd_count),
        .push_dropped (rd_push_dropped),
        .pop_ignored  (rd_pop_ignored)
    );

    // Injected idle cycles
    logic stall;
`ifdef MCB_RESP_STALL_INJECT_EN
    logic [15:0] lfsr_reg;

    // Free-running LFSR; bit 0 high requests an idle cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

    // Engine state
    engine_state_t state_reg, state_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [5:0]    beat_reg, beat_next;
    logic [5:0]    bl_reg, bl_next;
    logic [2:0]    instr_reg, instr_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          calib_done_reg, calib_done_next;
    logic          underrun_set;
    logic          ram_we;
    logic          ram_re;
    logic          wr_underrun_reg;
    logic          wr_error_reg;
    logic          rd_overflow_reg;
    logic          rd_error_reg;

    // Backing RAM split into byte lanes so masked bytes map onto byte enables
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] lane_q;

            // Byte-lane write and registered read
            always_ff @(posedge clk) begin
                if (ram_we && !wr_head[32+gi]) begin
                    lane_mem[addr_reg] <= wr_head[gi*8 +: 8];
                end
                if (ram_re) begin
                    lane_q <= lane_mem[addr_reg];
                end
            end

            assign ram_q[gi*8 +: 8] = lane_q;
        end
    endgenerate

    // Engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_CALIB;
            cnt_reg        <= '0;
            beat_reg       <= '0;
            bl_reg         <= '0;
            instr_reg      <= '0;
            addr_reg       <= '0;
            calib_done_reg <= 1'b0;
            rd_push_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            beat_reg       <= beat_next;
            bl_reg         <= bl_next;
            instr_reg      <= instr_next;
            addr_reg       <= addr_next;
            calib_done_reg <= calib_done_next;
            rd_push_reg    <= ram_re;
        end
    end

    // Engine next-state and datapath control
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        beat_next       = beat_reg;
        bl_next         = bl_reg;
        instr_next      = instr_reg;
        addr_next       = addr_reg;
        calib_done_next = calib_done_reg;
        underrun_set    = 1'b0;
        cmd_pop         = 1'b0;
        wr_pop          = 1'b0;
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        case (state_reg)
            ST_CALIB: begin
                if (cnt_reg == CALIB_LAST) begin
                    calib_done_next = 1'b1;
                    cnt_next        = '0;
                    state_next      = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_IDLE: begin
                if (!cmd_empty && !stall) begin
                    cmd_pop    = 1'b1;
                    instr_next = cmd_head[CMD_W-1 -: 3];
                    bl_next    = cmd_head[AW +: 6];
                    addr_next  = cmd_head[AW-1:0];
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                beat_next = '0;
                cnt_next  = '0;
                case (instr_reg)
                    INSTR_WRITE, INSTR_WRITE_AP: state_next = ST_WRITE;
                    INSTR_READ, INSTR_READ_AP:   state_next = (READ_LATENCY > 1) ? ST_RD_WAIT : ST_READ;
                    INSTR_REFRESH:               state_next = ST_REFRESH;
                    default:                     state_next = ST_IDLE;
                endcase
            end
            ST_WRITE: begin
                if (!stall) begin
                    if (wr_empty) begin
                        underrun_set = 1'b1;
                    end else begin
                        wr_pop    = 1'b1;
                        ram_we    = 1'b1;
                        addr_next = addr_reg + 1'b1;
                        if (beat_reg == bl_reg) begin
                            state_next = ST_IDLE;
                        end else begin
                            beat_next = beat_reg + 6'd1;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_reg == RD_WAIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_READ;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_READ: begin
                if (!stall) begin
                    ram_re    = 1'b1;
                    addr_next = addr_reg + 1'b1;
                    if (beat_reg == bl_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        beat_next = beat_reg + 6'd1;
                    end
                end
            end
            ST_REFRESH: begin
                if (cnt_reg == REFRESH_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_underrun_reg <= 1'b0;
            wr_error_reg    <= 1'b0;
            rd_overflow_reg <= 1'b0;
            rd_error_reg    <= 1'b0;
        end else begin
            wr_underrun_reg <= wr_underrun_reg | underrun_set;
            wr_error_reg    <= wr_error_reg | underrun_set | wr_push_dropped;
            rd_overflow_reg <= rd_overflow_reg | rd_push_dropped;
            rd_error_reg    <= rd_error_reg | rd_pop_ignored;
        end
    end

    assign calib_done  = calib_done_reg;
    assign wr_underrun = wr_underrun_reg;
    assign wr_error    = wr_error_reg;
    assign rd_overflow = rd_overflow_reg;
    assign rd_error    = rd_error_reg;

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed bench for mcb_port_responder with hand-computed expectations.
module tb_mcb_port_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        calib_done;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd_instr = '0;
    logic [5:0]  cmd_bl = '0;
    logic [29:0] cmd_byte_addr = '0;
    logic        cmd_empty, cmd_full;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_mask = '0;
    logic [31:0] wr_data = '0;
    logic        wr_full, wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun, wr_error;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_full, rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow, rd_error;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcb_port_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .calib_done    (calib_done),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_empty     (cmd_empty),
        .cmd_full      (cmd_full),
        .wr_en         (wr_en),
        .wr_mask       (wr_mask),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .wr_count      (wr_count),
        .wr_underrun   (wr_underrun),
        .wr_error      (wr_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_full       (rd_full),
        .rd_empty      (rd_empty),
        .rd_count      (rd_count),
        .rd_overflow   (rd_overflow),
        .rd_error      (rd_error)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // All drive tasks start and end on a falling edge
    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = addr;
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check_val(tag, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (int'(rd_count) != n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(rd_count), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_calib",  32'(calib_done), 32'd0);
        check_val("rst_empty",  32'({cmd_empty, wr_empty, rd_empty}), 32'h7);
        check_val("rst_full",   32'({cmd_full, wr_full, rd_full}), 32'h0);
        check_val("rst_counts", 32'({wr_count, rd_count}), 32'h0);
        check_val("rst_sticky", 32'({wr_underrun, wr_error, rd_overflow, rd_error}), 32'h0);
        check_val("rst_rddata", rd_data, 32'h0);

        // Calibration delay
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_val("calib_15", 32'(calib_done), 32'd0);
        check_val("flags_15", 32'({cmd_empty, wr_empty, rd_empty, wr_count, rd_count}), 32'h1C000);
        @(negedge clk);
        check_val("calib_16", 32'(calib_done), 32'd1);

        // Single write then read-back
        push_wr(32'hF0806020, 4'h0);
        check_val("wr_count1", 32'(wr_count), 32'd1);
        send_cmd(3'd0, 6'd0, 30'h40);
        repeat (10) @(negedge clk);
        check_val("wr_empty_before_rd", 32'(wr_empty), 32'd1);
        send_cmd(3'd1, 6'd0, 30'h40);
        wait_rd("rd1_count", 1, 40);
        check_val("rd1_empty", 32'(rd_empty), 32'd0);
        pop_check("rd1_data", 32'hF0806020);

        // Byte mask
        push_wr(32'hFFFFFFFF, 4'h0);
        send_cmd(3'd0, 6'd0, 30'h10);
        push_wr(32'h00000000, 4'b1010);
        send_cmd(3'd2, 6'd0, 30'h10);
        send_cmd(3'd3, 6'd0, 30'h10);
        wait_rd("mask_count", 1, 40);
        pop_check("mask_data", 32'hFF00FF00);
        check_val("no_errors", 32'({wr_underrun, wr_error, rd_overflow, rd_error}), 32'h0);

        // Underrun and stalled burst
        push_wr(32'h11111111, 4'h0);
        push_wr(32'h22222222, 4'h0);
        send_cmd(3'd0, 6'd3, 30'h80);
        repeat (10) @(negedge clk);
        check_val("underrun", 32'({wr_underrun, wr_error}), 32'h3);
        check_val("underrun_cmd_empty", 32'(cmd_empty), 32'd1);
        push_wr(32'h33333333, 4'h0);
        push_wr(32'h44444444, 4'h0);
        repeat (5) @(negedge clk);
        send_cmd(3'd1, 6'd3, 30'h80);
        wait_rd("burst4_count", 4, 60);
        pop_check("burst4_w0", 32'h11111111);
        pop_check("burst4_w1", 32'h22222222);
        pop_check("burst4_w2", 32'h33333333);
        pop_check("burst4_w3", 32'h44444444);

        // Read overflow: prefill 10, then a 64-word burst with nothing draining
        send_cmd(3'd1, 6'd9, 30'h80);
        wait_rd("prefill_count", 10, 60);
        check_val("prefill_ovf", 32'(rd_overflow), 32'd0);
        send_cmd(3'd1, 6'd63, 30'h0);
        wait_rd("ovf_count_reach", 64, 200);
        repeat (20) @(negedge clk);
        check_val("ovf_count", 32'(rd_count), 32'd64);
        check_val("ovf_flags", 32'({rd_full, rd_overflow, rd_empty}), 32'h6);
        check_val("ovf_head", rd_data, 32'h11111111);
        rd_en = 1'b1;
        repeat (65) @(negedge clk);
        rd_en = 1'b0;
        check_val("drain_flags", 32'({rd_empty, rd_full, rd_error}), 32'h5);
        check_val("drain_count", 32'(rd_count), 32'd0);

        // Address wrap at the top of memory, low byte-address bits ignored
        push_wr(32'hAAAA0001, 4'h0);
        push_wr(32'hBBBB0002, 4'h0);
        send_cmd(3'd0, 6'd1, 30'hFFE);
        repeat (10) @(negedge clk);
        send_cmd(3'd1, 6'd0, 30'hFFC);
        send_cmd(3'd1, 6'd0, 30'h1000);
        wait_rd("wrap_count", 2, 60);
        pop_check("wrap_w1023", 32'hAAAA0001);
        pop_check("wrap_w0", 32'hBBBB0002);
        send_cmd(3'd1, 6'd1, 30'hFFC);
        wait_rd("rdwrap_count", 2, 60);
        check_val("rdwrap_head", rd_data, 32'hAAAA0001);

        // Reset in the middle of a stalled write burst
        push_wr(32'h55555555, 4'h0);
        send_cmd(3'd0, 6'd3, 30'h200);
        send_cmd(3'd4, 6'd0, 30'h0);
        repeat (6) @(negedge clk);
        check_val("pre_rst_state", 32'({calib_done, cmd_empty, rd_count}), 32'h102);
        rst_n = 1'b0;
        #1;
        check_val("midrst_calib", 32'(calib_done), 32'd0);
        check_val("midrst_empty", 32'({cmd_empty, wr_empty, rd_empty}), 32'h7);
        check_val("midrst_counts", 32'({wr_count, rd_count}), 32'h0);
        check_val("midrst_sticky", 32'({wr_underrun, wr_error, rd_overflow, rd_error}), 32'h0);
        check_val("midrst_rddata", rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Refresh, then memory contents survive reset
        repeat (20) @(negedge clk);
        send_cmd(3'd4, 6'd0, 30'h0);
        send_cmd(3'd1, 6'd0, 30'h1000);
        wait_rd("post_rst_count", 1, 60);
        check_val("post_rst_data", rd_data, 32'hBBBB0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
